// File: rtl/ravenoc_pkg.sv
// Shared NoC definitions: flit type encoding, flit type field position and
// link transmitter packet states.
package ravenoc_pkg;

  typedef enum logic [1:0] {
    INVALID = 2'b00,
    HEAD    = 2'b01,
    BODY    = 2'b10,
    TAIL    = 2'b11
  } flit_type_t;

  // The type field occupies the top FLIT_TYPE_W bits of every flit.
  localparam int FLIT_TYPE_W       = 2;
  localparam int FLIT_TYPE_TOP_OFS = 1;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } tx_state_t;

endpackage

// File: rtl/flit_link_tx_if.sv
// Bundle of the FIFO-side, link-side and status signals of flit_link_tx.
interface flit_link_tx_if #(
  parameter int FLIT_WIDTH = 34,
  parameter int CREDITS    = 2
);
  localparam int CNT_W = $clog2(CREDITS + 1);

  logic                  fifo_empty_i;
  logic [FLIT_WIDTH-1:0] fifo_data_i;
  logic                  fifo_rd_o;
  logic [FLIT_WIDTH-1:0] flit_o;
  logic                  flit_valid_o;
  logic                  credit_i;
  logic [CNT_W-1:0]      credits_o;
  logic                  pkt_active_o;
  logic                  error_o;

  modport master (
    input  fifo_empty_i, fifo_data_i, credit_i,
    output fifo_rd_o, flit_o, flit_valid_o, credits_o, pkt_active_o, error_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, credit_i,
    input  fifo_rd_o, flit_o, flit_valid_o, credits_o, pkt_active_o, error_o
  );
endinterface

// File: rtl/flit_link_tx_checker.sv
// Protocol assertions for flit_link_tx (bound in unless NO_ASSERTIONS).
module flit_link_tx_checker #(
  parameter int CREDITS = 2,
  parameter int CNT_W   = $clog2(CREDITS + 1)
) (
  input logic             clk,
  input logic             arst,
  input logic             fifo_empty,
  input logic             fifo_rd,
  input logic [CNT_W-1:0] credits
);
  localparam bit CREDITS_OK = (CREDITS >= 1);

  a_credits_param: assert property (@(posedge clk) CREDITS_OK)
    else $error("CREDITS must be at least 1");

  a_cnt_max: assert property (@(posedge clk) disable iff (arst)
    credits <= CNT_W'(CREDITS))
    else $error("credit count above CREDITS");

  a_rd_empty: assert property (@(posedge clk) disable iff (arst)
    !(fifo_rd && fifo_empty))
    else $error("FIFO popped while empty");
endmodule

// File: rtl/flit_link_tx_credit_counter.sv
// Saturating downstream credit counter; overflow_o flags a credit returned
// while already full with no send in the same cycle.
module credit_counter #(
  parameter int CREDITS = 2,
  parameter int CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             dec_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             avail_o,
  output logic             overflow_o
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             overflow_s;

  // Next credit count from send/return events.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    overflow_s = 1'b0;
    case ({dec_i, inc_i})
      2'b10: cnt_nxt_s = cnt_r - CNT_W'(1);
      2'b01: begin
        if (cnt_r == FULL) begin
          overflow_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Credit count register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_r <= FULL;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign cnt_o      = cnt_r;
  assign avail_o    = (cnt_r != CNT_W'(0));
  assign overflow_o = overflow_s;
endmodule

// File: rtl/flit_link_tx.sv
// Credit-based NoC link transmitter draining an upstream flit FIFO.
// Optional packet framing check enabled by FLIT_TX_PKT_CHECK_EN.
module flit_link_tx
  import ravenoc_pkg::*;
#(
  parameter int FLIT_WIDTH = 34,
  parameter int CREDITS    = 2
) (
  input logic            clk,
  input logic            arst,
  flit_link_tx_if.master bus
);
  localparam int CNT_W = $clog2(CREDITS + 1);

  logic                  pop_s;
  logic                  send_s;
  logic                  drop_s;
  logic                  avail_s;
  logic                  overflow_s;
  logic [CNT_W-1:0]      cnt_s;
  logic [FLIT_WIDTH-1:0] flit_r;
  logic                  valid_r;
  logic                  err_r;

  // Popping is blocked during reset even though the counter sits at full.
  assign pop_s         = ~arst & ~bus.fifo_empty_i & avail_s;
  assign bus.fifo_rd_o = pop_s;

  credit_counter #(.CREDITS(CREDITS)) u_credit (
    .clk        (clk),
    .arst       (arst),
    .dec_i      (send_s),
    .inc_i      (bus.credit_i),
    .cnt_o      (cnt_s),
    .avail_o    (avail_s),
    .overflow_o (overflow_s)
  );

`ifdef FLIT_TX_PKT_CHECK_EN
  tx_state_t  state_r;
  tx_state_t  state_nxt_s;
  flit_type_t ftype_s;

  assign ftype_s = flit_type_t'(bus.fifo_data_i[FLIT_WIDTH-FLIT_TYPE_TOP_OFS -: FLIT_TYPE_W]);

  // Packet framing state register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Framing decision: out-of-order flits are consumed but dropped.
  always_comb begin
    state_nxt_s = state_r;
    send_s      = 1'b0;
    drop_s      = 1'b0;
    if (pop_s) begin
      case (state_r)
        IDLE: begin
          if (ftype_s == HEAD) begin
            send_s      = 1'b1;
            state_nxt_s = PKT;
          end else begin
            drop_s = 1'b1;
          end
        end
        PKT: begin
          case (ftype_s)
            BODY: send_s = 1'b1;
            TAIL: begin
              send_s      = 1'b1;
              state_nxt_s = IDLE;
            end
            default: drop_s = 1'b1;
          endcase
        end
        default: state_nxt_s = IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  assign bus.pkt_active_o = (state_r == PKT);
`else
  assign send_s           = pop_s;
  assign drop_s           = 1'b0;
  assign bus.pkt_active_o = 1'b0;
`endif

  // Link output and error pulse registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      flit_r  <= '0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      valid_r <= send_s;
      err_r   <= drop_s | overflow_s;
      if (send_s) begin
        flit_r <= bus.fifo_data_i;
      end
    end
  end

  assign bus.flit_o       = flit_r;
  assign bus.flit_valid_o = valid_r;
  assign bus.error_o      = err_r;
  assign bus.credits_o    = cnt_s;

`ifndef NO_ASSERTIONS
  flit_link_tx_checker #(.CREDITS(CREDITS)) u_chk (
    .clk        (clk),
    .arst       (arst),
    .fifo_empty (bus.fifo_empty_i),
    .fifo_rd    (pop_s),
    .credits    (cnt_s)
  );
`endif
endmodule

// File: doc/flit_link_tx.md
# flit_link_tx

Credit-based link transmitter that drains a flit FIFO and drives one NoC output link. It sits directly downstream of the input/output buffer FIFO. It pops a flit whenever the FIFO is non-empty and the downstream receiver has a free buffer slot. It registers the flit onto the link and tracks head/body/tail packet framing.

## Interface
Parameters:
- FLIT_WIDTH, default 34: flit width; bits [FLIT_WIDTH-1:FLIT_WIDTH-2] hold the flit type.
- CREDITS, default 2: downstream buffer depth; must be ≥1; equals the downstream FIFO SLOTS.

Ports:
- clk  input  1  clock
- arst  input  1  reset, asynchronous, active-high
- fifo_empty_i  input  1  upstream FIFO empty flag
- fifo_data_i  input  FLIT_WIDTH  upstream FIFO head data
- fifo_rd_o  output  1  pop strobe to the upstream FIFO, combinational
- flit_o  output  FLIT_WIDTH  link data, registered
- flit_valid_o  output  1  link flit valid, single-cycle pulse per flit
- credit_i  input  1  one-cycle pulse: downstream freed one slot
- credits_o  output  $clog2(CREDITS+1)  current credit count
- pkt_active_o  output  1  a packet is open (head sent, tail not yet sent)
- error_o  output  1  one-cycle pulse on a protocol or credit error

## Operation
- Flit types: 2'b00 invalid, 2'b01 head, 2'b10 body, 2'b11 tail.
- Send condition: `send = ~fifo_empty_i && (credit_cnt_ff != 0) && ~drop`.
  - `fifo_rd_o = ~fifo_empty_i && (credit_cnt_ff != 0)`.
  - A popped flit that is dropped is still consumed from the FIFO.
- Credit counter, width $clog2(CREDITS+1), reset value CREDITS:
  - send only: decrement by 1.
  - credit_i only: increment by 1.
  - send and credit_i in the same cycle: unchanged.
  - credit_i while count==CREDITS and no send: count saturates at CREDITS and error_o pulses.
  - A credit arriving in cycle N is usable in cycle N+1, never in the same cycle.
- Packet state machine, states IDLE and PKT:
  - IDLE + head: send; go to PKT.
  - PKT + body: send; stay in PKT.
  - PKT + tail: send; go to IDLE.
  - IDLE + body/tail/invalid: drop, error_o pulses, stay in IDLE.
  - PKT + head/invalid: drop, error_o pulses, stay in PKT.
- pkt_active_o = (state == PKT).

## Timing
- Reset values: flit_o=0, flit_valid_o=0, credits_o=CREDITS, pkt_active_o=0, error_o=0, state=IDLE.
- fifo_rd_o is 0 while arst is high.
- Latency: a flit popped in cycle N appears on flit_o with flit_valid_o=1 in cycle N+1.
- flit_o holds its last value when flit_valid_o=0.
- Throughput: 1 flit/cycle while credits are available.
- With CREDITS=2 and a link round trip above 2 cycles, the link stalls; this is expected.
- error_o is registered: asserted in cycle N+1 for an event in cycle N.
- Reset asserted mid-packet:
  - All state returns to reset values immediately.
  - In-flight credits are discarded.
  - The downstream FIFO must be reset by the same arst.

## Configuration
- FLIT_TX_PKT_CHECK_EN defined: the packet state machine and drop/error behaviour are as described above.
- FLIT_TX_PKT_CHECK_EN undefined:
  - Every popped flit is sent regardless of type.
  - pkt_active_o is tied to 0.
  - error_o reports credit overflow only.

## Structure
- Shared package ravenoc_pkg holds:
  - flit_type_t enum (INVALID, HEAD, BODY, TAIL).
  - Flit type field position constants.
  - tx_state_t enum (IDLE, PKT).
- Sub-module credit_counter (parameter CREDITS):
  - Inputs: dec_i, inc_i.
  - Outputs: cnt_o, avail_o, overflow_o.
  - Saturating behaviour as described under Operation.
- Assertions, enabled unless NO_ASSERTIONS is defined:
  - CREDITS ≥ 1.
  - credit count never exceeds CREDITS.
  - fifo_rd_o never asserted while fifo_empty_i=1.

## Test plan
1. Reset, CREDITS=2, FIFO holds head, body, tail; no credit_i.
   - Required: head and body sent in consecutive cycles, then stall with credits_o=0.
   - A credit_i pulse in cycle 10 releases the tail in cycle 12 (popped in 11, valid in 12).
2. Send and credit_i in the same cycle with credits_o=1.
   - Required: credits_o stays 1 and flit_valid_o=1 the next cycle.
3. credit_i with credits_o=2 (full) and no send.
   - Required: credits_o stays 2 and error_o pulses once.
4. Body flit (type 2'b10) with state IDLE, FLIT_TX_PKT_CHECK_EN defined.
   - Required: fifo_rd_o=1, no flit_valid_o, error_o=1 next cycle, credits_o unchanged.
   - Same stimulus without the macro: flit is sent and error_o stays 0.
5. Head then a second head.
   - Required: first head sent, second dropped with error, pkt_active_o stays 1.
   - A following tail is sent and pkt_active_o drops to 0.
6. arst asserted mid-packet with credits_o=0.
   - Required: credits_o=2, pkt_active_o=0, flit_valid_o=0 immediately.
   - A new head is sent 2 cycles after arst deasserts, with the FIFO refilled the cycle after deassertion.
